forth_stack: RTL

//  Parametrised TOS-cached hardware stack: data and return stack for the next-gen

---
 rtl/forth_stack.sv | 121 ++++++++++++
 1 files changed

// File: rtl/forth_stack.sv
// TOS-cached hardware stack: TOS in a register, lower items in an async-read
// register file addressed by a circular pointer. Saturating or wrapping overflow.
module forth_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int WRAP  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   op,
    input  logic                         tos_we,
    input  logic [WIDTH-1:0]             tos_in,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             tos,
    output logic [WIDTH-1:0]             nos,
    output logic [$clog2(DEPTH+2)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+2);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH + 1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } op_t;

    op_t              cmd;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr, ptr_dec, ptr_n, mem_addr;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] tos_n, mem_wdata;
    logic             mem_we, ovf_err, udf_err;

    assign cmd       = op_t'(op);
    assign ptr_dec   = ptr - 1'b1;
    assign nos       = mem[ptr_dec];
    assign depth     = cnt;
    assign empty     = (cnt == '0);
    assign full      = (cnt == FULL_CNT);

    always_comb begin
        tos_n     = tos;
        ptr_n     = ptr;
        cnt_n     = cnt;
        ovf_err   = 1'b0;
        udf_err   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ptr;
        mem_wdata = tos;
        case (cmd)
            OP_NONE: if (tos_we) tos_n = tos_in;
            OP_PUSH: begin
                if (full) begin
                    ovf_err = 1'b1;
                    // circular mode spills the old TOS over the oldest entry
                    if (WRAP != 0) begin
                        mem_we = 1'b1;
                        ptr_n  = ptr + 1'b1;
                        tos_n  = tos_in;
                    end
                end else begin
                    if (!empty) begin
                        mem_we = 1'b1;
                        ptr_n  = ptr + 1'b1;
                    end
                    tos_n = tos_in;
                    cnt_n = cnt + 1'b1;
                end
            end
            OP_POP: begin
                if (empty) begin
                    udf_err = 1'b1;
                    if (WRAP != 0) begin
                        tos_n = tos_we ? tos_in : nos;
                        ptr_n = ptr_dec;
                    end
                end else begin
                    tos_n = tos_we ? tos_in : ((cnt >= TWO) ? nos : '0);
                    if (cnt >= TWO) ptr_n = ptr_dec;
                    cnt_n = cnt - 1'b1;
                end
            end
            OP_SWAP: begin
                if (cnt < TWO) udf_err = 1'b1;
                if (cnt >= TWO || WRAP != 0) begin
                    tos_n    = nos;
                    mem_we   = 1'b1;
                    mem_addr = ptr_dec;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos       <= '0;
            ptr       <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tos       <= tos_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            overflow  <= ovf_err | (overflow & ~err_clr);
            underflow <= udf_err | (underflow & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) mem[mem_addr] <= mem_wdata;
    end
endmodule
